// File: rtl/clmul16_seq_ctrl_pkg.sv
// Shared definitions for the sequential carry-less multiplier controller.
//   DIGIT_W    : width of one operand digit fed to the 4x4 core
//   CORE_OUT_W : width of the 4x4 carry-less core product
//   calc_w/p   : operand and product widths derived from the digit count
//   state_t    : controller state encoding
package clmul16_seq_ctrl_pkg;

    localparam int DIGIT_W    = 4;
    localparam int CORE_OUT_W = 7;

    function automatic int calc_w(input int n_digits);
        return DIGIT_W * n_digits;
    endfunction

    // Degree of the product is at most 2W-2, so only 2W-1 bits are needed.
    function automatic int calc_p(input int n_digits);
        return 2 * DIGIT_W * n_digits - 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/clmul16_seq_ctrl_if.sv
// Operand/result handshake bundle for clmul16_seq_ctrl.
//   in_valid/in_ready/in_a/in_b : operand pair channel (source -> controller)
//   out_valid/out_ready/out_d   : product channel (controller -> sink)
//   modport slave  : controller side
//   modport master : environment side (operand source + result sink)
interface clmul16_seq_ctrl_if #(
    parameter int N_DIGITS = 4
);
    import clmul16_seq_ctrl_pkg::*;

    localparam int W = calc_w(N_DIGITS);
    localparam int P = calc_p(N_DIGITS);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [P-1:0] out_d;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_d
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_d
    );

endinterface

// File: rtl/clmul16_seq_ctrl_ks4.sv
// Combinational 4x4 carry-less multiplier using one Karatsuba level.
//   a, b : 4-bit polynomials over GF(2)
//   p    : 7-bit product a*b
// Three 2x2 products replace four: z1 = (a0^a1)(b0^b1) ^ z0 ^ z2.
module clmul16_seq_ctrl_ks4
    import clmul16_seq_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0]    a,
    input  logic [DIGIT_W-1:0]    b,
    output logic [CORE_OUT_W-1:0] p
);

    function automatic logic [2:0] mul2(input logic [1:0] x, input logic [1:0] y);
        return {x[1] & y[1], (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
    endfunction

    logic [2:0] z0;
    logic [2:0] z2;
    logic [2:0] zm;
    logic [2:0] z1;

    always_comb begin
        z0 = mul2(a[1:0], b[1:0]);
        z2 = mul2(a[3:2], b[3:2]);
        zm = mul2(a[1:0] ^ a[3:2], b[1:0] ^ b[3:2]);
        z1 = zm ^ z0 ^ z2;
        p  = {z2, 4'b0000} ^ {2'b00, z1, 2'b00} ^ {4'b0000, z0};
    end

endmodule

// File: rtl/clmul16_seq_ctrl.sv
// Sequential carry-less multiplier controller.
// One 4x4 core is reused for all N_DIGITS^2 digit pairs; partial products
// are shifted by 4*(i+j) and XOR-accumulated into the product register.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : operand/result handshake (slave side)
//   busy  : high while the digit-pair loop is running
module clmul16_seq_ctrl
    import clmul16_seq_ctrl_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    clmul16_seq_ctrl_if.slave  bus,
    output logic               busy
);

    localparam int W     = calc_w(N_DIGITS);
    localparam int P     = calc_p(N_DIGITS);
    localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIGITS - 1);

    state_t           state_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [P-1:0]     acc_reg;
    logic [CNT_W-1:0] i_reg;
    logic [CNT_W-1:0] j_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    // Digit views of the captured operands.
    logic [DIGIT_W-1:0] a_digit [N_DIGITS];
    logic [DIGIT_W-1:0] b_digit [N_DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign a_digit[gi] = a_reg[gi*DIGIT_W +: DIGIT_W];
            assign b_digit[gi] = b_reg[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    logic [CORE_OUT_W-1:0] core_p;
    logic [P-1:0]          shifted;

    clmul16_seq_ctrl_ks4 u_ks4 (
        .a (a_digit[i_reg]),
        .b (b_digit[j_reg]),
        .p (core_p)
    );

    // Highest placement is 4*(2N-2)+6 = P-1, so nothing is lost off the top.
    always_comb begin
        shifted = P'(core_p) << (DIGIT_W * (int'(i_reg) + int'(j_reg)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            i_reg         <= '0;
            j_reg         <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.in_a;
                        b_reg        <= bus.in_b;
                        acc_reg      <= '0;
                        i_reg        <= '0;
                        j_reg        <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    acc_reg <= acc_reg ^ shifted;
                    if (j_reg == LAST) begin
                        j_reg <= '0;
                        if (i_reg == LAST) begin
                            busy_reg      <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            i_reg <= i_reg + 1'b1;
                        end
                    end else begin
                        j_reg <= j_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_d     = acc_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_clmul16_seq_ctrl.sv
// Self-checking bench for clmul16_seq_ctrl: directed vector table,
// backpressure and mid-operation reset sequences, then random operands
// checked against a bitwise shift-XOR reference.
module tb_clmul16_seq_ctrl;

    localparam int N = 4;
    localparam int W = 16;
    localparam int P = 31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    clmul16_seq_ctrl_if #(.N_DIGITS(N)) bus ();

    clmul16_seq_ctrl #(.N_DIGITS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_op   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [P-1:0] exp;
        int           stall;
        bit           pulse;
    } vec_t;

    vec_t vecs [8];

    // Polynomial product by schoolbook shift-and-XOR over the bits of b.
    function automatic logic [P-1:0] ref_clmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [P-1:0] r;
        r = '0;
        for (int k = 0; k < W; k++) begin
            if (b[k]) r = r ^ (P'(a) << k);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction; out_ready held low for 'stall' cycles after
    // out_valid rises, optional ignored in_valid pulse in that window.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [P-1:0] exp, input int stall, input bit pulse);
        int waitc;
        int lat;
        waitc = 0;
        while (!bus.in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("in_ready_wait", 64'(bus.in_ready), 64'(1));
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = (stall == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
        check("busy_after_accept", 64'(busy), 64'(1));
        check("in_ready_low_busy", 64'(bus.in_ready), 64'(0));
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(N * N));
        check("out_d", 64'(bus.out_d), 64'(exp));
        check("busy_in_done", 64'(busy), 64'(0));
        $display("op %0d a=%h b=%h d=%h exp=%h lat=%0d stall=%0d",
                 n_op, a, b, bus.out_d, exp, lat, stall);
        n_op++;
        for (int s = 0; s < stall; s++) begin
            if (pulse && s == 0) begin
                bus.in_valid = 1'b1;
                bus.in_a     = W'($urandom);
                bus.in_b     = W'($urandom);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check("stall_out_valid", 64'(bus.out_valid), 64'(1));
            check("stall_out_d", 64'(bus.out_d), 64'(exp));
            check("stall_in_ready", 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_hs_out_valid", 64'(bus.out_valid), 64'(0));
        check("post_hs_in_ready", 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{16'h0003, 16'h0003, 31'h00000005, 0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 31'h55555555, 0, 1'b0};
        vecs[2] = '{16'h8000, 16'h8000, 31'h40000000, 0, 1'b0};
        vecs[3] = '{16'h1234, 16'h0001, 31'h00001234, 0, 1'b0};
        vecs[4] = '{16'h0001, 16'h1234, 31'h00001234, 1, 1'b0};
        vecs[5] = '{16'h0000, 16'hABCD, 31'h00000000, 2, 1'b0};
        vecs[6] = '{16'h00F0, 16'h0011, 31'h00000FF0, 5, 1'b1};
        vecs[7] = '{16'hABCD, 16'h0000, 31'h00000000, 0, 1'b0};

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_out_d", 64'(bus.out_d), 64'(0));
        rst_n = 1'b1;

        // Directed table, issued back to back
        for (int v = 0; v < 8; v++) begin
            do_op(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].stall, vecs[v].pulse);
        end

        // Backpressure with an ignored operand pulse, then a fresh op
        do_op(16'hFFFF, 16'h0101, ref_clmul(16'hFFFF, 16'h0101), 5, 1'b1);
        do_op(16'h0005, 16'h0007, 31'h0000001B, 0, 1'b0);

        // Reset on the 7th BUSY cycle
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h1234;
        bus.in_b     = 16'h5678;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midop_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midop_rst_busy", 64'(busy), 64'(0));
        check("midop_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midop_rst_out_d", 64'(bus.out_d), 64'(0));
        check("midop_rst_in_ready", 64'(bus.in_ready), 64'(1));
        do_op(16'h00F0, 16'h0011, 31'h00000FF0, 0, 1'b0);

        // Random regression
        for (int r = 0; r < 1000; r++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, ref_clmul(ra, rb), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/clmul16_seq_ctrl.md
Name: clmul16_seq_ctrl

Overview:
- Sequential controller that computes a 4*N_DIGITS-bit carry-less (GF(2)[x]) polynomial product.
- Time-multiplexes a single 4x4 Karatsuba core (ks4) over N_DIGITS^2 digit-pair products and XOR-accumulates the shifted partial products.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Trades area for latency against a fully unrolled multiplier.

Parameters:
- N_DIGITS, 4, number of 4-bit digits per operand; operand width W = 4*N_DIGITS, product width P = 2*W-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operand pair offered
- in_ready  output  1  controller can accept operands
- in_a  input  W  operand A, bit k = coefficient of x^k
- in_b  input  W  operand B
- out_valid  output  1  result available
- out_ready  input  1  sink accepts result
- out_d  output  P  carry-less product A*B
- busy  output  1  high while state is BUSY

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low. All state updates on the rising clk edge.
- Reset values, checked at any edge with rst_n=0:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, out_d=0.
  - Accumulator, digit counters i and j, and operand registers all 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture in_a/in_b into registers, clear accumulator, set i=0 and j=0, go to BUSY.
  - in_a/in_b need not stay stable after the accept edge.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle: core inputs are digit i of A and digit j of B (digit k = bits 4k+3:4k).
  - Accumulator ^= (7-bit core result) << 4*(i+j).
  - Counter order: j increments; on j = N_DIGITS-1, j wraps to 0 and i increments.
  - After the cycle with i = j = N_DIGITS-1: go to DONE.
  - Exactly N_DIGITS^2 BUSY cycles (16 at default).
- DONE:
  - out_valid=1; out_d = accumulator, stable while out_valid=1.
  - On out_valid & out_ready: go to IDLE. in_ready rises the cycle after the handshake.
- Latency: out_valid rises exactly N_DIGITS^2 cycles after the input-accept edge (16 at default). Minimum issue interval is N_DIGITS^2+2 cycles with out_ready held high.
- Handshake rules:
  - in_valid is ignored outside IDLE; no operand queueing.
  - out_ready held high before out_valid rises is legal; the handshake then completes on the first DONE cycle.
  - out_ready while out_valid=0 has no effect.
- Width rules:
  - All accumulation is XOR; there are no carries.
  - The shifted core result occupies bits 4(i+j)+6 : 4(i+j). It never exceeds bit P-1.
  - out_d has no bit P, because the degree is at most 2W-2.
- Reset mid-operation: rst_n=0 in BUSY or DONE discards the operation and forces reset values at that edge. The first transaction after reset is computed correctly.
- Zero operands: still run the full N_DIGITS^2 cycles and produce 0. There is no early termination.

Decomposition:
- Shared package holds:
  - Constants DIGIT_W=4, CORE_OUT_W=7.
  - Derived W and P as functions of N_DIGITS.
  - State enumeration IDLE/BUSY/DONE.
- One sub-module instance: ks4 (existing 4x4 Karatsuba core, purely combinational).
- The controller owns all registers, the counters, and the shift/XOR accumulation.

Test Plan:
- in_a=16'h0003, in_b=16'h0003, out_ready=1 -> out_d=31'h00000005. out_valid high exactly 16 cycles after the accept edge and held 1 cycle. in_ready back high on the following cycle.
- in_a=16'hFFFF, in_b=16'hFFFF -> out_d=31'h55555555. Second back-to-back op in_a=16'h8000, in_b=16'h8000 -> out_d=31'h40000000.
- in_a=16'h1234, in_b=16'h0001 -> out_d=31'h00001234. Swapped operands give the same result. in_a=16'h0000 gives 0 after a full 16 BUSY cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_d stable, in_ready=0. A new in_valid pulse during that window is ignored, and the next result corresponds only to operands offered after in_ready returns to 1.
- Reset mid-op: drive rst_n=0 on the 7th BUSY cycle -> next cycle state IDLE, busy=0, out_valid=0, out_d=0, in_ready=1. A following op in_a=16'h00F0, in_b=16'h0011 -> out_d=31'h00000FF0.
- Random regression: 1000 random operand pairs with random out_ready stalls, compared against a bitwise shift-XOR reference model. Zero mismatches; no dropped or duplicated results.
